// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage sitting directly in front of the decoder.
//
// Holds the fetch PC and issues word requests to instruction memory. Returned
// words are buffered with their PCs in a QDEPTH-entry FIFO and handed to decode
// with a valid/ready handshake. A redirect from execute flushes the queue and
// restarts fetch. Responses still in flight at that point are dropped when
// they arrive.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous active-high reset
//   imem_req     out  1   fetch request valid
//   imem_addr    out  32  fetch address, word aligned
//   imem_ready   in   1   memory accepts the request this cycle
//   imem_rvalid  in   1   in-order response valid
//   imem_rdata   in   32  response instruction word
//   redirect     in   1   flush and restart fetch
//   redirect_pc  in   32  restart address (low two bits ignored)
//   dec_valid    out  1   dec_instr/dec_pc valid
//   dec_instr    out  32  instruction to decoder
//   dec_pc       out  32  PC of dec_instr
//   dec_ready    in   1   decoder consumes the head entry
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W  = QDEPTH[CW:0];
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);

  logic [31:0]   fetchPc_r;
  logic [31:0]   respPc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] dropCnt_r;
  logic [CW-1:0] count_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [31:0]   qInstr_r [QDEPTH];
  logic [31:0]   qPc_r    [QDEPTH];

  logic [CW:0]   credit_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          dropResp_s;
  logic [CW-1:0] outstandingNext_s;
  logic [CW-1:0] countNext_s;
  logic [31:0]   redirAligned_s;
  logic [1:0]    unusedRedirLsb_s;

  // Queued entries plus requests in flight can never exceed the queue size,
  // so every response has a guaranteed slot and push needs no full check.
  assign credit_s   = {1'b0, count_r} + {1'b0, outstanding_r};
  assign imem_req   = (credit_s < DEPTH_W) & ~redirect & ~reset;
  assign accept_s   = imem_req & imem_ready;
  assign imem_addr  = fetchPc_r;

  assign dec_valid  = (count_r != CNT_ZERO);
  assign dec_instr  = qInstr_r[head_r];
  assign dec_pc     = qPc_r[head_r];

  assign dropResp_s = imem_rvalid & (dropCnt_r != CNT_ZERO);
  assign push_s     = imem_rvalid & ~redirect & (dropCnt_r == CNT_ZERO);
  assign pop_s      = dec_valid & dec_ready & ~redirect;

  assign redirAligned_s   = {redirect_pc[31:2], 2'b00};
  assign unusedRedirLsb_s = redirect_pc[1:0];

  // Requests in flight: +1 on accept, -1 on any response (kept or dropped).
  always_comb begin
    outstandingNext_s = outstanding_r;
    if (accept_s && !imem_rvalid) begin
      outstandingNext_s = outstanding_r + CNT_ONE;
    end else if (!accept_s && imem_rvalid) begin
      outstandingNext_s = outstanding_r - CNT_ONE;
    end else begin
      outstandingNext_s = outstanding_r;
    end
  end

  // Queue occupancy after this cycle's push and pop.
  always_comb begin
    countNext_s = count_r;
    if (push_s && !pop_s) begin
      countNext_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      countNext_s = count_r - CNT_ONE;
    end else begin
      countNext_s = count_r;
    end
  end

  // Fetch/response PCs, in-flight bookkeeping and queue pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchPc_r     <= RESET_PC;
      respPc_r      <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      dropCnt_r     <= CNT_ZERO;
      count_r       <= CNT_ZERO;
      head_r        <= PTR_ZERO;
      tail_r        <= PTR_ZERO;
    end else begin
      outstanding_r <= outstandingNext_s;
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old
        // path; the count to drop equals the post-update outstanding value.
        fetchPc_r <= redirAligned_s;
        respPc_r  <= redirAligned_s;
        dropCnt_r <= outstandingNext_s;
        count_r   <= CNT_ZERO;
        head_r    <= PTR_ZERO;
        tail_r    <= PTR_ZERO;
      end else begin
        if (accept_s) begin
          fetchPc_r <= fetchPc_r + 32'd4;
        end
        if (dropResp_s) begin
          dropCnt_r <= dropCnt_r - CNT_ONE;
        end
        if (push_s) begin
          respPc_r <= respPc_r + 32'd4;
          tail_r   <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        count_r <= countNext_s;
      end
    end
  end

  // Queue storage; reset so the idle head reads as instr 0 at RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qInstr_r[i] <= 32'h0000_0000;
        qPc_r[i]    <= RESET_PC;
      end
    end else begin
      if (push_s) begin
        qInstr_r[tail_r] <= imem_rdata;
        qPc_r[tail_r]    <= respPc_r;
      end
    end
  end

endmodule
